// File: rtl/regfile_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and types for the register-file arbiter slice.
//   DEPTH/ADDR_W/DATA_W describe the 64 x 16-bit general register array.
//   state_t is the two-state controller encoding (INIT sweep, RUN service).
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int DATA_W = 16;

    typedef logic [ADDR_W-1:0] reg_index_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : regfile_pkg

// File: rtl/regfile_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_arbiter_if
//   Request/response bundle between NUM_REQ requesters and the register file.
//
//   Handshake: a requester raises req_valid[i] with req_we/req_index/req_wdata
//   and holds all of them stable until req_ready[i] is seen high; a transfer
//   happens in the cycle where req_valid[i] & req_ready[i]. req_ready is
//   one-hot at most and is never withdrawn while valid stays high. Exactly one
//   cycle after a transfer, rsp_valid[i] pulses for one cycle with rsp_rdata
//   (read data, or the previous contents on a write). Responses cannot be
//   stalled; rsp_rdata holds its last value while rsp_valid is zero.
//
//   Modports:
//     master - requester side (drives req_*, observes ready and responses)
//     slave  - register file side (drives req_ready and rsp_*)
// ----------------------------------------------------------------------------
interface regfile_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import regfile_pkg::*;

    logic       [NUM_REQ-1:0] req_valid;
    logic       [NUM_REQ-1:0] req_we;
    reg_index_t [NUM_REQ-1:0] req_index;
    reg_data_t  [NUM_REQ-1:0] req_wdata;
    logic       [NUM_REQ-1:0] req_ready;
    logic       [NUM_REQ-1:0] rsp_valid;
    reg_data_t                rsp_rdata;

    modport master (
        output req_valid, req_we, req_index, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_index, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface : regfile_arbiter_if

// File: rtl/regfile_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin picker. Searches i_req starting at i_ptr
//   and wrapping modulo NUM_REQ; the first set bit wins. The pointer register
//   lives in the parent so it can be reset/held alongside the controller.
//
//   Ports:
//     i_req       - request vector
//     i_ptr       - starting position for the search
//     i_enable    - when low, no grant is produced
//     o_grant     - one-hot grant (all zero when nothing is granted)
//     o_grant_idx - binary index of the granted requester (0 when none)
//     o_grant_any - high when o_grant is non-zero
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_grant_idx,
    output logic               o_grant_any
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_sel;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_grant_any = 1'b0;
        w_sum       = '0;
        w_sel       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit holds ptr+k before folding back into range.
            w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= (PTR_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (PTR_W + 1)'(NUM_REQ);
            end
            w_sel = w_sum[PTR_W-1:0];
            if (i_enable && !o_grant_any && i_req[w_sel]) begin
                o_grant[w_sel] = 1'b1;
                o_grant_idx    = w_sel;
                o_grant_any    = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_arbiter
//   Owns the 64 x 16-bit register array and serves one read or write per cycle
//   to NUM_REQ requesters in round-robin order. After reset or a clear pulse
//   it spends exactly DEPTH cycles writing zeros to every entry (INIT) before
//   granting anything, so the array itself carries no reset.
//   Writes return the previous register contents (swap).
//
//   Ports:
//     clk          - rising-edge clock
//     rst_n        - synchronous active-low reset; beats clear and grants
//     clear        - one-cycle pulse, restarts the zeroing sweep
//     busy         - high while sweeping (INIT)
//     o_dbg_state  - controller state, for observation
//     o_dbg_rr_ptr - round-robin search start, for observation
//     bus          - request/response bundle (slave side)
// ----------------------------------------------------------------------------
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    output logic               busy,
    output state_t             o_dbg_state,
    output logic [PTR_W-1:0]   o_dbg_rr_ptr,
    regfile_arbiter_if.slave   bus
);

    // Storage: deliberately unreset, zeroed by the INIT sweep instead.
    reg_data_t r_regs [DEPTH];

    state_t             r_state;
    reg_index_t         r_init_cnt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [NUM_REQ-1:0] r_rsp_valid;
    reg_data_t          r_rsp_rdata;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_gidx;
    logic               w_grant_any;
    logic               w_enable;
    logic               w_we;
    reg_index_t         w_index;
    reg_data_t          w_wdata;

    assign w_enable = (r_state == RUN);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req       (bus.req_valid),
        .i_ptr       (r_rr_ptr),
        .i_enable    (w_enable),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_grant_any (w_grant_any)
    );

    // Selected requester's command fields.
    assign w_we    = bus.req_we[w_gidx];
    assign w_index = bus.req_index[w_gidx];
    assign w_wdata = bus.req_wdata[w_gidx];

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign busy          = r_busy;
    assign o_dbg_state   = r_state;
    assign o_dbg_rr_ptr  = r_rr_ptr;

    // Array write port. Grants only exist in RUN, so the sweep and a
    // requester write never collide. Nothing is written in a reset cycle.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == INIT) begin
                r_regs[r_init_cnt] <= '0;
            end else if (w_grant_any && w_we) begin
                r_regs[w_index] <= w_wdata;
            end
        end
    end

    // Controller: state, sweep counter, arbitration pointer and response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= INIT;
            r_init_cnt  <= '0;
            r_rr_ptr    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_busy      <= 1'b1;
        end else begin
            // A grant always completes, even alongside clear; the old
            // contents are captured for both reads and writes.
            r_rsp_valid <= w_grant;
            if (w_grant_any) begin
                r_rsp_rdata <= r_regs[w_index];
                r_rr_ptr    <= (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
            end

            case (r_state)
                INIT: begin
                    r_init_cnt <= r_init_cnt + 1'b1;
                    if (r_init_cnt == reg_index_t'(DEPTH - 1)) begin
                        r_state <= RUN;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_state <= INIT;
                    r_busy  <= 1'b1;
                end
            endcase

            // clear wins over the state update above, including mid-sweep.
            if (clear) begin
                r_state    <= INIT;
                r_init_cnt <= '0;
                r_busy     <= 1'b1;
            end
        end
    end

endmodule : regfile_arbiter

// File: doc/regfile_arbiter.md
# regfile_arbiter

Owns the 64 x 16-bit general register array and shares it among NUM_REQ requesters through a round-robin arbiter, performing one read or write per cycle. After reset, or on a clear command, it sweeps the array to zero before accepting traffic, so the storage itself needs no reset. It sits between the execution/control units and the register storage, and is the only writer of the array.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DEPTH, 64: register count; fixed at 2**ADDR_W
- ADDR_W, 6: index width
- DATA_W, 16: register width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- clear  in  1  single-cycle pulse; re-zeroes the array
- req_valid  in  NUM_REQ  request present, per requester
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_index  in  NUM_REQ x ADDR_W  target register
- req_wdata  in  NUM_REQ x DATA_W  write data
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid & ready
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_rdata  out  DATA_W  shared response data; qualified by rsp_valid
- busy  out  1  high while in INIT

## Operation
- **States:** INIT, RUN.
- **Reset** (rst_n low at an edge):
  - state = INIT, init_cnt = 0, rr_ptr = 0.
  - rsp_valid = 0, rsp_rdata = 0.
  - busy = 1 from the first post-reset cycle.
- **INIT:**
  - Each cycle writes regs[init_cnt] = 0, then increments init_cnt.
  - At init_cnt == DEPTH-1 the write occurs and the state moves to RUN. INIT takes exactly DEPTH cycles.
  - req_ready = 0 throughout.
- **RUN:**
  - Grant the first requester with req_valid = 1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready is combinational from req_valid and rr_ptr, and is at most one-hot.
  - On a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ. With no grant, rr_ptr holds.
- **Read** (we = 0): rsp_rdata <= regs[index].
- **Write** (we = 1): regs[index] <= wdata, and rsp_rdata <= the old regs[index] (swap semantics).
- **Response:** every grant, read or write, produces a response.
- **clear:**
  - Sampled in any state. Next state is INIT with init_cnt = 0.
  - A grant issued in the same cycle as clear still completes and responds.
  - clear during INIT restarts the sweep from 0.
- **Indices:** all are full-range (0..63); no out-of-range case exists. Widths are exact, with no truncation.

## Timing
- Grant at cycle t: rsp_valid[g] = 1 and rsp_rdata are valid in cycle t+1, for exactly one cycle. There is no response backpressure; the requester must accept.
- Throughput is one access per cycle. A given requester may be granted in consecutive cycles only if no other requester is valid.
- A write granted at t is visible to a read granted at t+1.
- rsp_rdata holds its last value while rsp_valid = 0.
- Requesters hold req_valid, req_we, req_index and req_wdata stable until granted; the arbiter never withdraws a grant.
- rst_n overrides clear and any in-flight grant. An access granted in the reset cycle is dropped, with no response.

## Structure
- **Package regfile_pkg:**
  - Constants: DEPTH, ADDR_W, DATA_W.
  - Typedefs: reg_index_t, reg_data_t.
  - State enum: state_t {INIT, RUN}.
- **Sub-module rr_arbiter:**
  - Parameter: NUM_REQ.
  - Inputs: req, ptr, enable.
  - Outputs: one-hot grant and a binary grant index.
  - Purely combinational; rr_ptr lives in the parent.
- The array, read select, INIT counter and response register live in regfile_arbiter.

## Test plan
- **Reset/INIT:** deassert rst_n → busy high and req_ready = 0 for 64 cycles, then busy = 0. Read each of regs 0..63 → every rsp_rdata = 0x0000.
- **Write/read:**
  - Requester 1 writes 0xBEEF to index 63 → ack next cycle with rsp_rdata = 0x0000.
  - Requester 2 reads index 63 in the following cycle → rsp_rdata = 0xBEEF on rsp_valid[2].
- **Fairness:** all four requesters held valid for 8 cycles with rr_ptr = 0 → grant order 0,1,2,3,0,1,2,3, and each rsp_valid appears one cycle after its grant.
- **clear mid-traffic:**
  - Fill index 5 with 0x1234, then pulse clear in the same cycle as a read of index 5 → that read returns 0x1234.
  - busy then asserts for 64 cycles, after which index 5 reads 0x0000.
- **Reset mid-operation:** assert rst_n low while requester 0 is granted → no rsp_valid follows, rr_ptr = 0, and a full INIT sweep restarts.
